// File: rtl/hdma_ctrl.sv
// HDMA/GDMA controller: copies 16-byte blocks from the external bus into VRAM,
// either all at once (general DMA) or one block per horizontal blank.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no transfer; CTRL write with bit7=0 starts GDMA, bit7=1 HDMA
// GDMA   | all remaining blocks back-to-back, CPU stalled throughout
// HWAIT  | HDMA armed, waiting for the next hblank rising edge
// HBLOCK | HDMA copying exactly one block, CPU stalled
module hdma_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mmio_a,
  input  logic [7:0]  mmio_din,
  output logic [7:0]  mmio_dout,
  input  logic        mmio_rd,
  input  logic        mmio_wr,
  input  logic        hblank,
  output logic [15:0] dma_a,
  input  logic [7:0]  dma_din,
  output logic [7:0]  dma_dout,
  output logic        dma_rd,
  output logic        dma_wr,
  output logic        occupy_extbus,
  output logic        occupy_vidbus,
  output logic        cpu_stall
);

  typedef enum logic [1:0] {IDLE, GDMA, HWAIT, HBLOCK} state_t;

  state_t      state, state_nxt;
  logic [7:0]  src_hi;
  logic [3:0]  src_lo;
  logic [4:0]  dst_hi;
  logic [3:0]  dst_lo;
  logic [15:0] src_cnt;
  logic [12:0] dst_cnt;   // offset into 0x8000-0x9FFF, wraps naturally
  logic [6:0]  remaining;
  logic [1:0]  phase;
  logic [3:0]  byte_cnt;
  logic [7:0]  data_q;
  logic        hblank_q;
  logic        cancel;

  logic wr_ctrl, stop_req, transferring, block_end, hblank_rise, load;

  assign wr_ctrl      = mmio_wr && (mmio_a == 16'hFF55);
  assign stop_req     = wr_ctrl && !mmio_din[7];
  assign transferring = (state == GDMA) || (state == HBLOCK);
  assign block_end    = transferring && (phase == 2'd3) && (byte_cnt == 4'hF);
  assign hblank_rise  = hblank && !hblank_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and bus outputs
  always_comb begin
    state_nxt     = state;
    load          = 1'b0;
    dma_rd        = 1'b0;
    dma_wr        = 1'b0;
    dma_a         = 16'h0000;
    dma_dout      = data_q;
    occupy_extbus = transferring;
    occupy_vidbus = transferring;
    cpu_stall     = transferring;
    case (state)
      IDLE: begin
        if (wr_ctrl) begin
          load      = 1'b1;
          state_nxt = mmio_din[7] ? HWAIT : GDMA;
        end
      end
      GDMA: begin
        if (block_end && remaining == 7'd0) state_nxt = IDLE;
      end
      HWAIT: begin
        if (stop_req)         state_nxt = IDLE;
        else if (hblank_rise) state_nxt = HBLOCK;
      end
      HBLOCK: begin
        // A stop arriving on the very last byte must still end the run.
        if (block_end)
          state_nxt = (remaining == 7'd0 || cancel || stop_req) ? IDLE : HWAIT;
      end
      default: state_nxt = IDLE;
    endcase
    if (transferring) begin
      dma_rd = !phase[1];
      dma_wr = (phase == 2'd2);
      dma_a  = phase[1] ? {3'b100, dst_cnt} : src_cnt;
    end
  end

  // CPU register read path; only CTRL carries information
  always_comb begin
    mmio_dout = 8'hFF;
    if (mmio_rd && mmio_a == 16'hFF55) mmio_dout = {state == IDLE, remaining};
  end

  // Registers, counters and byte sequencing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_hi    <= 8'h00;
      src_lo    <= 4'h0;
      dst_hi    <= 5'h00;
      dst_lo    <= 4'h0;
      src_cnt   <= 16'h0000;
      dst_cnt   <= 13'h0000;
      remaining <= 7'h7F;
      phase     <= 2'd0;
      byte_cnt  <= 4'h0;
      data_q    <= 8'h00;
      hblank_q  <= 1'b0;
      cancel    <= 1'b0;
    end else begin
      hblank_q <= hblank;
      if (mmio_wr) begin
        case (mmio_a)
          16'hFF51: src_hi <= mmio_din;
          16'hFF52: src_lo <= mmio_din[7:4];
          16'hFF53: dst_hi <= mmio_din[4:0];
          16'hFF54: dst_lo <= mmio_din[7:4];
          default: ;
        endcase
      end
      if (load) begin
        src_cnt   <= {src_hi, src_lo, 4'h0};
        dst_cnt   <= {dst_hi, dst_lo, 4'h0};
        remaining <= mmio_din[6:0];
        phase     <= 2'd0;
        byte_cnt  <= 4'h0;
        cancel    <= 1'b0;
      end else if (transferring) begin
        phase <= phase + 2'd1;
        if (phase == 2'd1) data_q <= dma_din;
        if (phase == 2'd3) begin
          src_cnt  <= src_cnt + 16'd1;
          dst_cnt  <= dst_cnt + 13'd1;
          byte_cnt <= byte_cnt + 4'd1;
        end
        if (block_end) remaining <= remaining - 7'd1;
        if (state == HBLOCK && stop_req) cancel <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hdma_ctrl.sv
// Directed bench for hdma_ctrl: a queue of expected (source, destination, data)
// bytes is built from the register values, and a per-cycle monitor checks
// every bus strobe against the head of that queue.
module tb_hdma_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mmio_a;
  logic [7:0]  mmio_din;
  logic [7:0]  mmio_dout;
  logic        mmio_rd, mmio_wr;
  logic        hblank;
  logic [15:0] dma_a;
  logic [7:0]  dma_din;
  logic [7:0]  dma_dout;
  logic        dma_rd, dma_wr;
  logic        occupy_extbus, occupy_vidbus, cpu_stall;

  hdma_ctrl dut (
    .clk(clk), .rst(rst),
    .mmio_a(mmio_a), .mmio_din(mmio_din), .mmio_dout(mmio_dout),
    .mmio_rd(mmio_rd), .mmio_wr(mmio_wr),
    .hblank(hblank),
    .dma_a(dma_a), .dma_din(dma_din), .dma_dout(dma_dout),
    .dma_rd(dma_rd), .dma_wr(dma_wr),
    .occupy_extbus(occupy_extbus), .occupy_vidbus(occupy_vidbus),
    .cpu_stall(cpu_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] src;
    logic [15:0] dst;
    logic [7:0]  data;
  } xfer_t;

  xfer_t       expq[$];
  logic [15:0] log_wa[$];
  logic [7:0]  log_wd[$];
  logic [15:0] log_ra[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          occ_cycles = 0;
  int          cyc = 0;
  int          last_wr_cyc = -1;
  logic        prev_rd = 1'b0;

  function automatic logic [7:0] mem_f(logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected byte stream of nblk blocks, straight from the address rules
  task automatic push_blocks(input logic [15:0] src, input logic [12:0] doff, input int nblk);
    for (int i = 0; i < nblk * 16; i++) begin
      xfer_t x;
      logic [12:0] o;
      x.src  = src + 16'(i);
      o      = doff + 13'(i);
      x.dst  = {3'b100, o};
      x.data = mem_f(x.src);
      expq.push_back(x);
    end
  endtask

  // Source memory: data valid the clock after a read address
  always @(posedge clk) if (dma_rd) dma_din <= mem_f(dma_a);

  // Per-cycle monitor
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_rd     = 1'b0;
      last_wr_cyc = -1;
    end else begin
      check("occupy_extbus_vs_stall", occupy_extbus, cpu_stall);
      check("occupy_vidbus_vs_stall", occupy_vidbus, cpu_stall);
      check("rd_wr_exclusive", dma_rd & dma_wr, 0);
      if (!cpu_stall) begin
        check("idle_strobes", {dma_rd, dma_wr}, 0);
        check("idle_addr", dma_a, 0);
        last_wr_cyc = -1;
      end else begin
        occ_cycles++;
      end
      if (dma_rd) begin
        check("rd_expected", expq.size() > 0, 1);
        if (expq.size() > 0) check("rd_addr", dma_a, expq[0].src);
        if (!prev_rd) log_ra.push_back(dma_a);
      end
      if (dma_wr) begin
        check("wr_expected", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          xfer_t x;
          x = expq.pop_front();
          check("wr_addr", dma_a, x.dst);
          check("wr_data", dma_dout, x.data);
        end
        log_wa.push_back(dma_a);
        log_wd.push_back(dma_dout);
        if (last_wr_cyc >= 0) check("wr_spacing", cyc - last_wr_cyc, 4);
        last_wr_cyc = cyc;
      end
      prev_rd = dma_rd;
    end
  end

  task automatic mmio_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    mmio_a = a; mmio_din = d; mmio_wr = 1'b1;
    @(negedge clk);
    mmio_wr = 1'b0; mmio_a = 16'h0000;
  endtask

  task automatic mmio_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    mmio_a = a; mmio_rd = 1'b1;
    #1 d = mmio_dout;
    mmio_rd = 1'b0; mmio_a = 16'h0000;
  endtask

  task automatic check_ctrl(string name, logic [7:0] exp);
    logic [7:0] d;
    mmio_read(16'hFF55, d);
    check(name, d, exp);
  endtask

  task automatic set_regs(input logic [7:0] sh, sl, dh, dl);
    mmio_write(16'hFF51, sh);
    mmio_write(16'hFF52, sl);
    mmio_write(16'hFF53, dh);
    mmio_write(16'hFF54, dl);
  endtask

  // Wait for a busy period (stall high, then low) to finish, bounded
  task automatic wait_done(string name, input int budget);
    int n = 0;
    bit seen;
    seen = cpu_stall;
    while (n < budget && !(seen && !cpu_stall)) begin
      @(negedge clk); #1;
      if (cpu_stall) seen = 1'b1;
      n++;
    end
    check(name, seen && !cpu_stall, 1);
  endtask

  task automatic hblank_pulse(string name);
    @(negedge clk); hblank = 1'b1;
    wait_done(name, 200);
    @(negedge clk); hblank = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int o, nw;
    rst = 1'b1; mmio_a = 0; mmio_din = 0; mmio_rd = 0; mmio_wr = 0; hblank = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    @(negedge clk); #1;
    check("reset_stall", {cpu_stall, occupy_extbus, occupy_vidbus}, 0);
    check("reset_strobes", {dma_rd, dma_wr}, 0);
    check_ctrl("reset_ctrl", 8'hFF);
    mmio_read(16'hFF51, d);
    check("read_src_hi", d, 8'hFF);

    // General DMA, one block
    log_wa.delete(); log_wd.delete(); log_ra.delete();
    set_regs(8'hC0, 8'h00, 8'h00, 8'h00);
    push_blocks(16'hC000, 13'h0000, 1);
    o = occ_cycles;
    mmio_write(16'hFF55, 8'h00);
    wait_done("gdma_done", 300);
    check("gdma_stall_cycles", occ_cycles - o, 64);
    check("gdma_queue_empty", expq.size(), 0);
    check("gdma_nwrites", log_wa.size(), 16);
    check("gdma_first_wa", log_wa[0], 16'h8000);
    check("gdma_last_wa", log_wa[15], 16'h800F);
    check("gdma_first_wd", log_wd[0], 8'h9A);
    check("gdma_last_wd", log_wd[15], 8'h95);
    check("gdma_first_ra", log_ra[0], 16'hC000);
    check_ctrl("gdma_ctrl_after", 8'hFF);

    // HDMA, three blocks, with ignored writes between blocks
    log_wa.delete(); log_wd.delete(); log_ra.delete();
    set_regs(8'hC1, 8'h20, 8'h01, 8'h40);
    push_blocks(16'hC120, 13'h0140, 3);
    o = occ_cycles;
    mmio_write(16'hFF55, 8'h82);
    repeat (10) @(negedge clk);
    check("hdma_no_start_without_hblank", occ_cycles - o, 0);
    hblank_pulse("hdma_blk1_done");
    check("hdma_blk1_cycles", occ_cycles - o, 64);
    check_ctrl("hdma_ctrl_blk1", 8'h01);
    mmio_write(16'hFF51, 8'h12);
    mmio_write(16'hFF55, 8'h85);
    check_ctrl("hdma_ctrl_restart_ignored", 8'h01);
    repeat (20) @(negedge clk);
    check("hdma_idle_gap", occ_cycles - o, 64);
    hblank_pulse("hdma_blk2_done");
    check_ctrl("hdma_ctrl_blk2", 8'h00);
    hblank_pulse("hdma_blk3_done");
    check_ctrl("hdma_ctrl_blk3", 8'hFF);
    check("hdma_total_cycles", occ_cycles - o, 192);
    check("hdma_queue_empty", expq.size(), 0);
    check("hdma_blk2_first_wa", log_wa[16], 16'h8150);
    check("hdma_blk3_first_ra", log_ra[32], 16'hC140);

    // Cancel while waiting for hblank
    set_regs(8'hC2, 8'h00, 8'h02, 8'h00);
    push_blocks(16'hC200, 13'h0200, 1);
    mmio_write(16'hFF55, 8'h85);
    hblank_pulse("cancel_wait_blk1_done");
    check_ctrl("cancel_wait_ctrl_active", 8'h04);
    mmio_write(16'hFF55, 8'h00);
    check_ctrl("cancel_wait_ctrl", 8'h84);
    o = occ_cycles;
    @(negedge clk); hblank = 1'b1;
    repeat (80) @(negedge clk);
    hblank = 1'b0;
    check("cancel_wait_no_more", occ_cycles - o, 0);
    check("cancel_wait_queue_empty", expq.size(), 0);

    // Cancel during a block: the block still completes
    set_regs(8'hC3, 8'h00, 8'h03, 8'h00);
    push_blocks(16'hC300, 13'h0300, 1);
    mmio_write(16'hFF55, 8'h83);
    o = occ_cycles;
    @(negedge clk); hblank = 1'b1;
    repeat (10) @(negedge clk);
    mmio_write(16'hFF55, 8'h00);
    wait_done("cancel_blk_done", 200);
    hblank = 1'b0;
    check("cancel_blk_cycles", occ_cycles - o, 64);
    check("cancel_blk_queue_empty", expq.size(), 0);
    check_ctrl("cancel_blk_ctrl", 8'h82);
    o = occ_cycles;
    @(negedge clk); hblank = 1'b1;
    repeat (80) @(negedge clk);
    hblank = 1'b0;
    check("cancel_blk_no_more", occ_cycles - o, 0);

    // Source and destination wrap
    log_wa.delete(); log_wd.delete(); log_ra.delete();
    set_regs(8'hFF, 8'hF0, 8'h1F, 8'hF0);
    push_blocks(16'hFFF0, 13'h1FF0, 2);
    o = occ_cycles;
    mmio_write(16'hFF55, 8'h01);
    wait_done("wrap_done", 400);
    check("wrap_cycles", occ_cycles - o, 128);
    check("wrap_queue_empty", expq.size(), 0);
    check("wrap_blk1_last_wa", log_wa[15], 16'h9FFF);
    check("wrap_blk2_first_wa", log_wa[16], 16'h8000);
    check("wrap_blk2_first_ra", log_ra[16], 16'h0000);
    check_ctrl("wrap_ctrl", 8'hFF);

    // HDMA started while hblank is already high
    set_regs(8'hC4, 8'h00, 8'h04, 8'h00);
    push_blocks(16'hC400, 13'h0400, 1);
    @(negedge clk); hblank = 1'b1;
    repeat (2) @(negedge clk);
    o = occ_cycles;
    mmio_write(16'hFF55, 8'h80);
    repeat (30) @(negedge clk);
    check("hb_high_no_start", occ_cycles - o, 0);
    hblank = 1'b0;
    repeat (10) @(negedge clk);
    check("hb_low_no_start", occ_cycles - o, 0);
    hblank = 1'b1;
    wait_done("hb_rise_done", 200);
    hblank = 1'b0;
    check("hb_rise_cycles", occ_cycles - o, 64);
    check("hb_queue_empty", expq.size(), 0);
    check_ctrl("hb_ctrl", 8'hFF);

    // Reset in the middle of a general DMA
    set_regs(8'hC5, 8'h00, 8'h05, 8'h00);
    push_blocks(16'hC500, 13'h0500, 4);
    mmio_write(16'hFF55, 8'h03);
    repeat (100) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_abort_wr", dma_wr, 0);
    check("rst_abort_rd", dma_rd, 0);
    check("rst_abort_stall", cpu_stall, 0);
    expq.delete();
    nw = log_wa.size();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("rst_no_more_writes", log_wa.size(), nw);
    check_ctrl("rst_ctrl", 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hdma_ctrl.md
HDMA_CTRL -- requirements
Module: hdma_ctrl

Interface
REQ-001 SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-002 clk  input  1  system clock (4.19 MHz); all state changes on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 mmio_a  input  16  CPU address; only 0xFF51-0xFF55 are decoded.
REQ-005 mmio_din  input  8  CPU write data.
REQ-006 mmio_dout  output  8  register read data, combinational.
REQ-007 mmio_rd / mmio_wr  input  1 each  CPU read/write strobes; mmio_wr is a one-clock pulse, gated by top-level decode.
REQ-008 hblank  input  1  PPU mode-0 level; high during horizontal blank.
REQ-009 dma_a  output  16  transfer address (source during read phases, VRAM destination during write phases).
REQ-010 dma_din  input  8  source data, valid on the clock after an address/rd is presented.
REQ-011 dma_dout  output  8  data to VRAM.
REQ-012 dma_rd / dma_wr  output  1 each  source read strobe / VRAM write strobe.
REQ-013 occupy_extbus / occupy_vidbus  output  1 each  bus ownership flags for the top-level muxes.
REQ-014 cpu_stall  output  1  CPU must freeze while high.

Function
REQ-015 SHALL implement registers: 0xFF51 SRC_HI, 0xFF52 SRC_LO (bits 3:0 ignored), 0xFF53 DST_HI (bits 4:0 used), 0xFF54 DST_LO (bits 3:0 ignored), 0xFF55 CTRL; reads of 0xFF51-0xFF54 return 0xFF.
REQ-016 Source start = {SRC_HI, SRC_LO[7:4], 4'h0}; destination start = 0x8000 | {DST_HI[4:0], DST_LO[7:4], 4'h0}.
REQ-017 Length = (CTRL[6:0]+1) blocks of 16 bytes; remaining-block counter is 7 bits.
REQ-018 States: IDLE, GDMA, HWAIT, HBLOCK.
REQ-019 IDLE, write CTRL with bit7=0 -> load counters, go to GDMA; bit7=1 -> load counters, go to HWAIT.
REQ-020 GDMA: transfer all blocks back-to-back, then return to IDLE.
REQ-021 HWAIT: on a hblank rising edge (registered 0->1), go to HBLOCK; if hblank is already high at start, wait for the next rising edge.
REQ-022 HBLOCK: transfer exactly one block; then go to IDLE if it was the last block or a cancel is pending, else go to HWAIT.
REQ-023 Write CTRL with bit7=0 in HWAIT -> go to IDLE immediately; in HBLOCK -> set cancel pending, finish the current block, then go to IDLE.
REQ-024 Write CTRL with bit7=1 while HWAIT/HBLOCK -> ignored.
REQ-025 Writes to 0xFF51-0xFF54 while active update the registers only; they do not affect the running counters.
REQ-026 Byte timing, 4 clocks per byte:
  - P0, P1: dma_a = src, dma_rd = 1.
  - End of P1: capture dma_din into the data register.
  - P2: dma_a = dst, dma_wr = 1, dma_dout = data register.
  - P3: dma_a = dst, no strobes; src += 1, dst += 1.
  - Result: 64 clocks per block.
REQ-027 Src increment wraps 0xFFFF -> 0x0000; dst wraps 0x9FFF -> 0x8000 (13-bit offset).
REQ-028 Remaining counter decrements at the end of each block; after the final block it wraps to 0x7F.
REQ-029 occupy_extbus, occupy_vidbus and cpu_stall SHALL be high exactly for every clock of GDMA and HBLOCK, low otherwise.
REQ-030 CTRL read = {~active, remaining[6:0]}, where active = state is not IDLE; after normal completion it reads 0xFF; after a cancel it reads {1, remaining}.
REQ-031 dma_rd and dma_wr SHALL never be high in the same clock; outside transfers both are 0 and dma_a = 0x0000.

Reset
REQ-032 On rst: state IDLE, all registers and counters 0x00 except remaining = 0x7F.
REQ-033 After rst, all strobes and occupy/stall outputs are 0, and CTRL reads 0xFF.
REQ-034 rst asserted mid-transfer SHALL abort immediately with no further dma_wr.

Verification
REQ-035 GDMA: SRC=0xC000, DST=0x8000, write CTRL=0x00 -> 16 dma_wr pulses at 0x8000-0x800F, 4 clocks apart, with data from 0xC000-0xC00F; cpu_stall high for 64 clocks; CTRL reads 0xFF afterwards.
REQ-036 HDMA: write CTRL=0x82, then three hblank pulses -> one 16-byte block per pulse; CTRL reads 0x01, then 0x00, then 0xFF; no bus occupancy between blocks.
REQ-037 Cancel: HDMA CTRL=0x85, one block done, then write CTRL=0x00 while in HWAIT -> no further transfers; CTRL reads 0x84 (bit7 set, remaining 0x04).
REQ-038 Cancel during HBLOCK: the current block completes all 16 writes, then state is IDLE.
REQ-039 Wrap: SRC=0xFFF0, DST_HI=0x1F, DST_LO=0xF0, CTRL=0x01 -> second block reads from 0x0000 and writes to 0x8000.
REQ-040 Start HDMA while hblank is high -> no transfer until hblank falls and rises again.
